// File: rtl/entrada_tempo_pkg.sv
// Shared constants, key codes and FSM encoding for the keypad time-entry controller.
package entrada_tempo_pkg;

    localparam int NDIG     = 4;
    localparam int DBITS    = 4;
    localparam int MAX_SECT = 5;
    localparam int CBITS    = $clog2(NDIG + 1);

    localparam logic [3:0] KEY_START  = 4'd10;
    localparam logic [3:0] KEY_CANCEL = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/entrada_tempo_digit_shift_reg.sv
// NDIG x DBITS digit shift register; new digits enter at the least-significant
// position and are dropped once the saturating digit counter reaches NDIG.
module entrada_tempo_digit_shift_reg
    import entrada_tempo_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  shift_en,
    input  logic [DBITS-1:0]      din,
    output logic [NDIG*DBITS-1:0] digits
);

    logic [NDIG*DBITS-1:0] digits_q;
    logic [NDIG*DBITS-1:0] digits_d;
    logic [CBITS-1:0]      count_q;
    logic [CBITS-1:0]      count_d;

    always_comb begin
        digits_d = digits_q;
        count_d  = count_q;
        if (clr) begin
            digits_d = '0;
            count_d  = '0;
        end else if (shift_en && (count_q < CBITS'(NDIG))) begin
            digits_d = {digits_q[(NDIG-1)*DBITS-1:0], din};
            count_d  = count_q + CBITS'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q <= '0;
            count_q  <= '0;
        end else begin
            digits_q <= digits_d;
            count_q  <= count_d;
        end
    end

    assign digits = digits_q;

endmodule

// File: rtl/entrada_tempo.sv
// Keypad MM:SS entry and run controller driving a cascaded BCD timer chain:
// collects digits, issues an active-low load strobe, then enables counting until 00:00.
module entrada_tempo
    import entrada_tempo_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       count_end,
    output logic [3:0] data_su,
    output logic [3:0] data_st,
    output logic [3:0] data_mu,
    output logic [3:0] data_mt,
    output logic       load,
    output logic       en,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] dbg_state
);

    state_t state_q;
    state_t state_d;
    logic   first_q;
    logic   first_d;
    logic   load_q, load_d;
    logic   en_q, en_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   err_q, err_d;
    logic   shift_en;
    logic   clr_digits;
    logic   start_reject;
    logic   is_dig, is_start, is_cancel;
    logic [NDIG*DBITS-1:0] digits;

    // key_valid is a one-cycle strobe with no back-pressure: a key is consumed
    // in exactly the cycle it is presented, or not at all.
    assign is_dig    = key_valid && is_digit(key_code);
    assign is_start  = key_valid && (key_code == KEY_START);
    assign is_cancel = key_valid && (key_code == KEY_CANCEL);

    assign start_reject = (digits == '0) ||
                          (digits[DBITS +: DBITS] > DBITS'(MAX_SECT));

    entrada_tempo_digit_shift_reg u_digits (
        .clk      (clk),
        .rst      (clear),
        .clr      (clr_digits),
        .shift_en (shift_en),
        .din      (key_code),
        .digits   (digits)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
            load_q  <= 1'b1;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            load_q  <= load_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // first_q marks the first RUN cycle, when count_end still reflects the pre-load value.
    always_comb begin
        state_d    = state_q;
        shift_en   = 1'b0;
        clr_digits = 1'b0;
        first_d    = (state_q == ST_LOAD);
        case (state_q)
            ST_IDLE: begin
                if (is_dig) begin
                    shift_en = 1'b1;
                    state_d  = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (is_dig) begin
                    shift_en = 1'b1;
                end else if (is_cancel) begin
                    clr_digits = 1'b1;
                    state_d    = ST_IDLE;
                end else if (is_start && !start_reject) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                if (is_cancel) begin
                    clr_digits = 1'b1;
                    state_d    = ST_IDLE;
                end else if (count_end && !first_q) begin
                    clr_digits = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                clr_digits = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load_d = (state_d != ST_LOAD);
        en_d   = (state_d == ST_RUN);
        busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        err_d  = (state_q == ST_ENTRY) && is_start && start_reject;
    end

    assign data_su   = digits[0*DBITS +: DBITS];
    assign data_st   = digits[1*DBITS +: DBITS];
    assign data_mu   = digits[2*DBITS +: DBITS];
    assign data_mt   = digits[3*DBITS +: DBITS];
    assign load      = load_q;
    assign en        = en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_entrada_tempo.sv
// Bench for entrada_tempo: directed scenarios plus randomized entries, with a
// scoreboard of expected load/err/done events and their digit values.
module tb_entrada_tempo;

    localparam int W = 18;
    localparam logic [1:0] K_LOAD = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;
    localparam logic [1:0] K_DONE = 2'd3;

    logic       clk;
    logic       clear;
    logic       key_valid;
    logic [3:0] key_code;
    logic       count_end;
    logic [3:0] data_su, data_st, data_mu, data_mt;
    logic       load, en, busy, done, err;
    logic [2:0] dbg_state;

    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    entrada_tempo dut (
        .clk       (clk),
        .clear     (clear),
        .key_valid (key_valid),
        .key_code  (key_code),
        .count_end (count_end),
        .data_su   (data_su),
        .data_st   (data_st),
        .data_mu   (data_mu),
        .data_mt   (data_mt),
        .load      (load),
        .en        (en),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // scoreboard: every load strobe, err pulse and done pulse must match the queue head
    always @(negedge clk) begin
        logic [W-1:0] obs;
        logic [W-1:0] e;
        logic [1:0]   kind;
        if (!clear && (load === 1'b0 || err === 1'b1 || done === 1'b1)) begin
            kind = (load === 1'b0) ? K_LOAD : ((err === 1'b1) ? K_ERR : K_DONE);
            obs  = {kind, data_mt, data_mu, data_st, data_su};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got=%h expected=none", obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    failures++;
                    $display("FAIL sb_event got=%h expected=%h", obs, e);
                end
            end
        end
    end

    // driver tasks: all enter and leave at posedge+1
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'd15;
    endtask

    task automatic test_reset();
        clear     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        count_end = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({load, en, busy, done, err} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b expected=10000", {load, en, busy, done, err});
        end
        checks++;
        if ({data_mt, data_mu, data_st, data_su, dbg_state} !== 19'd0) begin
            failures++;
            $display("FAIL reset_data got=%h state=%0d expected=0", {data_mt, data_mu, data_st, data_su}, dbg_state);
        end
        key_valid = 1'b1;
        key_code  = 4'd7;
        tick();
        checks++;
        if ({data_su, dbg_state} !== 7'd0) begin
            failures++;
            $display("FAIL clear_over_key got su=%0d state=%0d expected 0/0", data_su, dbg_state);
        end
        key_valid = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic test_load_sequence();
        press(4'd1);
        press(4'd3);
        press(4'd0);
        checks++;
        if ({data_mt, data_mu, data_st, data_su} !== 16'h0130 || dbg_state !== 3'd1 || load !== 1'b1) begin
            failures++;
            $display("FAIL entry_digits got=%h state=%0d load=%b expected=0130/1/1",
                     {data_mt, data_mu, data_st, data_su}, dbg_state, load);
        end
        exp_q.push_back({K_LOAD, 16'h0130});
        press(4'd10);
        checks++;
        if ({load, en, busy} !== 3'b001 || dbg_state !== 3'd2) begin
            failures++;
            $display("FAIL load_cycle got load/en/busy=%b state=%0d expected=001/2", {load, en, busy}, dbg_state);
        end
        tick();
        checks++;
        if ({load, en, busy} !== 3'b111 || dbg_state !== 3'd3) begin
            failures++;
            $display("FAIL run_entry got load/en/busy=%b state=%0d expected=111/3", {load, en, busy}, dbg_state);
        end
    endtask

    task automatic test_run_done();
        count_end = 1'b1;
        tick();
        count_end = 1'b0;
        checks++;
        if (en !== 1'b1 || dbg_state !== 3'd3 || done !== 1'b0) begin
            failures++;
            $display("FAIL first_cycle_ignore got en=%b state=%0d done=%b expected=1/3/0", en, dbg_state, done);
        end
        press(4'd5);
        checks++;
        if ({data_mt, data_mu, data_st, data_su} !== 16'h0130) begin
            failures++;
            $display("FAIL run_digit_ignored got=%h expected=0130", {data_mt, data_mu, data_st, data_su});
        end
        tick();
        tick();
        count_end = 1'b1;
        exp_q.push_back({K_DONE, 16'h0000});
        tick();
        count_end = 1'b0;
        checks++;
        if ({en, done, busy} !== 3'b010 || dbg_state !== 3'd4 || {data_mt, data_mu, data_st, data_su} !== 16'h0) begin
            failures++;
            $display("FAIL done_pulse got en/done/busy=%b state=%0d data=%h expected=010/4/0000",
                     {en, done, busy}, dbg_state, {data_mt, data_mu, data_st, data_su});
        end
        tick();
        checks++;
        if (done !== 1'b0 || dbg_state !== 3'd0) begin
            failures++;
            $display("FAIL done_end got done=%b state=%0d expected=0/0", done, dbg_state);
        end
    endtask

    task automatic test_entry_saturate();
        for (int i = 1; i <= 5; i++) press(4'(i));
        press(4'd13);
        checks++;
        if ({data_mt, data_mu, data_st, data_su} !== 16'h1234 || dbg_state !== 3'd1) begin
            failures++;
            $display("FAIL saturate got=%h state=%0d expected=1234/1", {data_mt, data_mu, data_st, data_su}, dbg_state);
        end
        exp_q.push_back({K_LOAD, 16'h1234});
        press(4'd10);
        checks++;
        if (load !== 1'b0 || data_mt !== 4'd1 || data_su !== 4'd4) begin
            failures++;
            $display("FAIL saturate_load got load=%b mt=%0d su=%0d expected=0/1/4", load, data_mt, data_su);
        end
        tick();
        tick();
    endtask

    task automatic test_cancel_run();
        key_valid = 1'b1;
        key_code  = 4'd11;
        count_end = 1'b1;
        tick();
        key_valid = 1'b0;
        count_end = 1'b0;
        checks++;
        if ({en, done, busy} !== 3'b000 || dbg_state !== 3'd0 || {data_mt, data_mu, data_st, data_su} !== 16'h0) begin
            failures++;
            $display("FAIL cancel_run got en/done/busy=%b state=%0d data=%h expected=000/0/0000",
                     {en, done, busy}, dbg_state, {data_mt, data_mu, data_st, data_su});
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL cancel_no_done got done=%b expected=0", done);
        end
    endtask

    task automatic test_reject();
        press(4'd0);
        press(4'd7);
        press(4'd5);
        exp_q.push_back({K_ERR, 16'h0075});
        press(4'd10);
        checks++;
        if ({err, load, busy} !== 3'b110 || dbg_state !== 3'd1) begin
            failures++;
            $display("FAIL reject_st got err/load/busy=%b state=%0d expected=110/1", {err, load, busy}, dbg_state);
        end
        tick();
        checks++;
        if (err !== 1'b0 || {data_mt, data_mu, data_st, data_su} !== 16'h0075) begin
            failures++;
            $display("FAIL reject_keep got err=%b data=%h expected=0/0075", err, {data_mt, data_mu, data_st, data_su});
        end
        press(4'd11);
        press(4'd0);
        exp_q.push_back({K_ERR, 16'h0000});
        press(4'd10);
        checks++;
        if (err !== 1'b1 || dbg_state !== 3'd1) begin
            failures++;
            $display("FAIL reject_zero got err=%b state=%0d expected=1/1", err, dbg_state);
        end
        press(4'd11);
    endtask

    task automatic test_idle_start();
        press(4'd10);
        checks++;
        if ({err, load, busy} !== 3'b010 || dbg_state !== 3'd0) begin
            failures++;
            $display("FAIL idle_start got err/load/busy=%b state=%0d expected=010/0", {err, load, busy}, dbg_state);
        end
        press(4'd11);
        press(4'd14);
        checks++;
        if (dbg_state !== 3'd0 || {data_mt, data_mu, data_st, data_su} !== 16'h0) begin
            failures++;
            $display("FAIL idle_ignore got state=%0d data=%h expected=0/0000", dbg_state, {data_mt, data_mu, data_st, data_su});
        end
    endtask

    task automatic test_clear_mid_run();
        press(4'd2);
        exp_q.push_back({K_LOAD, 16'h0002});
        press(4'd10);
        tick();
        #2;
        clear = 1'b1;
        #1;
        checks++;
        if ({load, en, busy, done, err} !== 5'b10000 || dbg_state !== 3'd0 || {data_mt, data_mu, data_st, data_su} !== 16'h0) begin
            failures++;
            $display("FAIL clear_mid_run got ctrl=%b state=%0d data=%h expected=10000/0/0000",
                     {load, en, busy, done, err}, dbg_state, {data_mt, data_mu, data_st, data_su});
        end
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            logic [15:0] m;
            int          cnt;
            int          n;
            logic [3:0]  d;
            m   = 16'h0;
            cnt = 0;
            n   = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                d = 4'($urandom_range(0, 9));
                if (cnt < 4) begin
                    m = {m[11:0], d};
                    cnt++;
                end
                press(d);
            end
            if (m == 16'h0 || m[7:4] > 4'd5) begin
                exp_q.push_back({K_ERR, m});
                press(4'd10);
                checks++;
                if (err !== 1'b1 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_reject m=%h got err=%b busy=%b expected=1/0", m, err, busy);
                end
                press(4'd11);
            end else begin
                exp_q.push_back({K_LOAD, m});
                press(4'd10);
                tick();
                repeat ($urandom_range(1, 5)) tick();
                checks++;
                if (en !== 1'b1 || {data_mt, data_mu, data_st, data_su} !== m) begin
                    failures++;
                    $display("FAIL rand_run m=%h got en=%b data=%h expected en=1", m, en, {data_mt, data_mu, data_st, data_su});
                end
                count_end = 1'b1;
                exp_q.push_back({K_DONE, 16'h0000});
                tick();
                count_end = 1'b0;
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_sequence();
        test_run_done();
        test_entry_saturate();
        test_cancel_run();
        test_reject();
        test_idle_start();
        test_clear_mid_run();
        test_random();
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d pending expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
